// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer.
// Fetches an 8-bit instruction into IR, decodes its opcode class and produces
// the per-cycle control strobes for the PC, register file, accumulator and
// data memory. It also counts retired instructions and halts on HALT, on an
// illegal opcode, or when data memory does not answer in time.
`timescale 1ns/1ps

module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instr,
  input  logic        imem_valid,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        acc_we,
  output logic [2:0]  reg_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        error,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_LI,
    CL_LD,
    CL_ST,
    CL_HALT,
    CL_ALU,
    CL_ILLEGAL
  } op_class_t;

  state_t      state_q, state_d;
  logic [7:0]  ir_q, ir_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] retired_q, retired_d;
  logic        error_q, error_d;
  logic [4:0]  opcode;
  op_class_t   op_class;

  assign opcode  = ir_q[7:3];
  assign reg_sel = ir_q[2:0];
  assign state   = state_q;
  assign halted  = (state_q == HALT);
  assign error   = error_q;
  assign retired = retired_q;

  // Map the IR opcode field onto its instruction class.
  always_comb begin
    op_class = CL_ILLEGAL;
    if (opcode[4]) begin
      op_class = CL_ALU;
    end else begin
      case (opcode[3:0])
        4'b0000: op_class = CL_NOP;
        4'b0001: op_class = CL_LI;
        4'b0010: op_class = CL_LD;
        4'b0011: op_class = CL_ST;
        4'b0111: op_class = CL_HALT;
        default: op_class = CL_ILLEGAL;
      endcase
    end
  end

  // Next-state, next-register and strobe decode for the sequencer.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    acc_we     = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_load = 1'b1;
          ir_d    = instr;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        case (op_class)
          CL_NOP: begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
          CL_LI: begin
            reg_we  = 1'b1;
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
          CL_ALU: begin
            acc_we  = 1'b1;
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
          CL_LD, CL_ST: begin
            dmem_req   = 1'b1;
            dmem_we    = (op_class == CL_ST);
            wait_cnt_d = '0;
            state_d    = MEM_WAIT;
          end
          CL_HALT: begin
            state_d = HALT;
          end
          default: begin
            error_d = 1'b1;
            state_d = HALT;
          end
        endcase
      end

      MEM_WAIT: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == CL_ST);
        // A ready on the last allowed wait cycle still completes normally.
        if (mem_ready) begin
          pc_inc  = 1'b1;
          reg_we  = (op_class == CL_LD);
          state_d = FETCH;
        end else if (wait_cnt_q == 4'hF) begin
          error_d = 1'b1;
          state_d = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        error_d = 1'b1;
        state_d = HALT;
      end
    endcase
  end

  // Retired-instruction counter advances with every PC increment and wraps.
  assign retired_d = retired_q + {15'd0, pc_inc};

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock domain; reset is synchronous and active-low.
REQ-002 Ports SHALL be:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-low reset, sampled on rising clk
instr  in  8  instruction byte from program memory
imem_valid  in  1  instr valid this cycle
mem_ready  in  1  data-memory transfer complete
imem_req  out  1  program-memory fetch request
ir_load  out  1  latch instr into IR (1-cycle pulse)
pc_inc  out  1  advance PC (1-cycle pulse per retired instruction)
dmem_req  out  1  data-memory request
dmem_we  out  1  data-memory write (1 = ST, 0 = LD)
reg_we  out  1  register-file write strobe
acc_we  out  1  accumulator write strobe (ALU ops)
reg_sel  out  3  IR[2:0], register index / immediate
state  out  3  current FSM state
halted  out  1  FSM in HALT
error  out  1  halt caused by illegal opcode or memory timeout
retired  out  16  retired-instruction count

Function
REQ-003 The block SHALL hold an 8-bit IR; opcode = IR[7:3].
REQ-004 Opcode classes SHALL be: 00000 NOP, 00001 LI, 00010 LD, 00011 ST, 00111 HALT, 1xxxx ALU; 00100-00110 and 01000-01111 illegal.
REQ-005 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM_WAIT=3, HALT=4; encodings 5-7 SHALL go to HALT with error=1.
REQ-006 FETCH: imem_req=1; when imem_valid=1, ir_load=1 and IR<=instr on that edge, next DECODE; otherwise stay.
REQ-007 DECODE: all strobes 0; next EXEC.
REQ-008 EXEC, NOP: pc_inc=1, next FETCH.
REQ-009 EXEC, LI: reg_we=1, pc_inc=1, next FETCH.
REQ-010 EXEC, ALU: acc_we=1, pc_inc=1, next FETCH.
REQ-011 EXEC, LD/ST: dmem_req=1, dmem_we=(opcode==ST), wait counter cleared, next MEM_WAIT.
REQ-012 MEM_WAIT: dmem_req=1 and dmem_we held; on mem_ready=1, pc_inc=1, reg_we=1 if LD, next FETCH.
REQ-013 MEM_WAIT without mem_ready: 4-bit wait counter increments; if counter==15 and mem_ready=0, next HALT with error=1, no pc_inc.
REQ-014 mem_ready and counter==15 in the same cycle SHALL complete normally (ready wins).
REQ-015 EXEC, HALT opcode: next HALT, error=0, no pc_inc; EXEC, illegal opcode: next HALT, error=1, no pc_inc.
REQ-016 HALT: all strobes 0, halted=1; exit only via reset.
REQ-017 imem_valid outside FETCH and mem_ready outside MEM_WAIT SHALL be ignored.
REQ-018 retired SHALL increment by 1 on every cycle with pc_inc=1, wrapping 0xFFFF->0x0000.
REQ-019 Strobes (imem_req, ir_load, pc_inc, dmem_req, dmem_we, reg_we, acc_we) SHALL be combinational from state, IR, counter, imem_valid and mem_ready; reg_sel=IR[2:0] at all times.
REQ-020 Minimum latency: NOP/LI/ALU 3 cycles per instruction; LD/ST 4 cycles with mem_ready in first MEM_WAIT cycle.

Reset
REQ-021 When reset=0 at a rising edge: state<=FETCH, IR<=0x00, wait counter<=0, retired<=0, error<=0; takes precedence over all transitions.
REQ-022 After reset edge: imem_req=1, halted=0, all other strobes 0; reset asserted mid-MEM_WAIT drops dmem_req the cycle after the edge with no pc_inc.

Verification
REQ-023 LI: instr=0x0D with imem_valid=1 in FETCH -> ir_load cycle 0, DECODE cycle 1, reg_we=1, pc_inc=1, reg_sel=5 cycle 2; retired=1.
REQ-024 ST: instr=0x1A, mem_ready=1 on 3rd MEM_WAIT cycle -> dmem_req=1, dmem_we=1 for 4 cycles (EXEC+3), pc_inc on ready cycle, reg_we never 1.
REQ-025 LD timeout: instr=0x12, mem_ready held 0 -> 16 MEM_WAIT cycles then HALT, halted=1, error=1, retired unchanged; mem_ready on 16th cycle instead -> normal completion with reg_we=1.
REQ-026 HALT/illegal: 0x38 -> HALT error=0; 0x40 -> HALT error=1; later imem_valid ignored until reset=0.
REQ-027 Wrap: 65536 NOPs -> retired returns to 0x0000; reset=0 during DECODE -> state=FETCH next cycle, retired=0.
